// File: rtl/cpu5_pkg.sv
// Shared definitions for the 5-bit CPU: widths, opcodes, instruction field slices and the
// instruction fetch state encoding.
package cpu5_pkg;

  localparam int unsigned ADDR_W        = 5;
  localparam int unsigned INSTR_W       = 9;
  localparam int unsigned FETCH_TIMEOUT = 15;

  // Instruction word layout: [8:5] opcode, [4:0] immediate.
  localparam int unsigned OPC_MSB = 8;
  localparam int unsigned OPC_LSB = 5;
  localparam int unsigned IMM_MSB = 4;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_HALT = 4'b1110;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StPresent,
    StHalt,
    StFault
  } fetch_state_e;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: synchronous reset to RESET_PC, load wins over increment,
// wraps modulo 2^AW.
module pc_counter #(
  parameter int unsigned   AW       = 5,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + AW'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words from program ROM over req/ack and presents
// opcode/immediate to the control unit with valid/ready. Stops on HALT or a memory timeout.
module instr_fetch_unit
  import cpu5_pkg::*;
#(
  parameter int unsigned   AW       = ADDR_W,
  parameter int unsigned   IW       = INSTR_W,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [3:0]    HALT_OP  = OP_HALT,
  parameter int unsigned   TIMEOUT  = FETCH_TIMEOUT
) (
  input  logic          CLK,
  input  logic          RST,
  output logic          MEM_REQ,
  output logic [AW-1:0] MEM_ADDR,
  input  logic          MEM_ACK,
  input  logic [IW-1:0] MEM_DATA,
  output logic [3:0]    Opcode,
  output logic [4:0]    IMM,
  output logic          INSTR_VALID,
  input  logic          INSTR_READY,
  input  logic          JMP_SEL,
  input  logic [AW-1:0] JMP_TGT,
  output logic [AW-1:0] PC,
  output logic          HALTED,
  output logic          FAULT,
  output logic [7:0]    RETIRED
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  fetch_state_e  state_q;
  logic          mem_req_q;
  logic          instr_valid_q;
  logic          halted_q;
  logic          fault_q;
  logic [3:0]    opcode_q;
  logic [4:0]    imm_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    retired_q;
  logic [AW-1:0] pc;

  logic consume;
  logic advance;

  // Valid is only ever high in StPresent, so consume needs no state decode.
  assign consume = instr_valid_q & INSTR_READY;
  assign advance = consume & (opcode_q != HALT_OP);

  pc_counter #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clk      (CLK),
    .rst      (RST),
    .load     (advance & JMP_SEL),
    .inc      (advance & ~JMP_SEL),
    .load_val (JMP_TGT),
    .pc       (pc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= StIdle;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
      opcode_q      <= '0;
      imm_q         <= '0;
      tmo_q         <= '0;
      retired_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q   <= StFetch;
          mem_req_q <= 1'b1;
          tmo_q     <= '0;
        end
        StFetch: begin
          if (MEM_ACK) begin
            opcode_q      <= MEM_DATA[OPC_MSB:OPC_LSB];
            imm_q         <= MEM_DATA[IMM_MSB:IMM_LSB];
            tmo_q         <= '0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= StPresent;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            // This was the last allowed wait cycle with the request up.
            mem_req_q <= 1'b0;
            fault_q   <= 1'b1;
            state_q   <= StFault;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        StPresent: begin
          if (consume) begin
            instr_valid_q <= 1'b0;
            if (retired_q != 8'hFF) begin
              retired_q <= retired_q + 8'd1;
            end
            if (opcode_q == HALT_OP) begin
              halted_q <= 1'b1;
              state_q  <= StHalt;
            end else begin
              mem_req_q <= 1'b1;
              tmo_q     <= '0;
              state_q   <= StFetch;
            end
          end
        end
        StHalt, StFault: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign MEM_REQ     = mem_req_q;
  assign MEM_ADDR    = pc;
  assign Opcode      = opcode_q;
  assign IMM         = imm_q;
  assign INSTR_VALID = instr_valid_q;
  assign PC          = pc;
  assign HALTED      = halted_q;
  assign FAULT       = fault_q;
  assign RETIRED     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a ROM responder with random wait states, a random
// execute stage, and a program-level reference model of PC sequencing, retire count and stops.
module tb_instr_fetch_unit;

  localparam logic [3:0] HALT = 4'b1110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_req;
  logic [4:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [8:0] mem_data = '0;
  logic [3:0] opcode;
  logic [4:0] imm;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       jmp_sel = 1'b0;
  logic [4:0] jmp_tgt = '0;
  logic [4:0] pc;
  logic       halted;
  logic       fault;
  logic [7:0] retired;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .CLK         (clk),
    .RST         (rst),
    .MEM_REQ     (mem_req),
    .MEM_ADDR    (mem_addr),
    .MEM_ACK     (mem_ack),
    .MEM_DATA    (mem_data),
    .Opcode      (opcode),
    .IMM         (imm),
    .INSTR_VALID (instr_valid),
    .INSTR_READY (instr_ready),
    .JMP_SEL     (jmp_sel),
    .JMP_TGT     (jmp_tgt),
    .PC          (pc),
    .HALTED      (halted),
    .FAULT       (fault),
    .RETIRED     (retired)
  );

  logic [8:0] rom [32];
  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  // Stimulus knobs
  bit rom_on, stray_en;
  int lat_fixed, lat_max, ready_pct, jmp_pct, jmp_fix, ready_limit;
  int rsp_wait, rsp_lat;

  // Reference model: program-level view of the fetch unit
  bit         m_start, m_fetch, m_valid, m_halt, m_fault;
  int         m_pc, m_wait, m_ret, consumed;
  logic [8:0] m_word;

  int addr_log[$];
  int op_log[$];
  int pc_log[$];
  int first_valid_cyc, req_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick_lat();
    return (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(lat_max));
  endfunction

  task automatic model_reset();
    m_start = 1; m_fetch = 0; m_valid = 0; m_halt = 0; m_fault = 0;
    m_pc = 0; m_wait = 0; m_ret = 0; consumed = 0; m_word = '0;
    cyc = 0; first_valid_cyc = -1; req_cnt = 0;
    rsp_wait = 0; rsp_lat = pick_lat();
  endtask

  task automatic model_step(input bit ack, input bit rdy, input bit js, input int tgt);
    if (m_start) begin
      m_start = 0; m_fetch = 1; m_wait = 0;
    end else if (m_fetch) begin
      if (ack) begin
        m_word = rom[m_pc]; m_fetch = 0; m_valid = 1;
      end else begin
        m_wait++;
        if (m_wait == 15) begin
          m_fetch = 0; m_fault = 1;
        end
      end
    end else if (m_valid && rdy) begin
      consumed++;
      if (m_ret < 255) m_ret++;
      m_valid = 0;
      if (m_word[8:5] == HALT) begin
        m_halt = 1;
      end else begin
        m_pc = js ? tgt : (m_pc + 1) % 32;
        m_fetch = 1; m_wait = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("req", 32'(mem_req), 32'(m_fetch));
    check_eq("valid", 32'(instr_valid), 32'(m_valid));
    check_eq("halted", 32'(halted), 32'(m_halt));
    check_eq("fault", 32'(fault), 32'(m_fault));
    check_eq("retired", 32'(retired), 32'(m_ret));
    check_eq("pc", 32'(pc), 32'(m_pc));
    if (m_fetch) check_eq("addr", 32'(mem_addr), 32'(m_pc));
    if (m_valid) begin
      check_eq("opcode", 32'(opcode), 32'(m_word[8:5]));
      check_eq("imm", 32'(imm), 32'(m_word[4:0]));
    end
  endtask

  task automatic cycle();
    bit req_pre, newly;
    req_pre  = mem_req;
    mem_ack  = 1'b0;
    mem_data = 9'($urandom);
    if (stray_en && m_start) begin
      mem_ack = 1'b1;  // DUT is idle here and must ignore it
    end else if (mem_req && rom_on && rsp_wait == rsp_lat) begin
      mem_ack  = 1'b1;
      mem_data = rom[mem_addr];
      addr_log.push_back(int'(mem_addr));
    end
    instr_ready = (consumed < ready_limit) && ($urandom_range(99) < ready_pct);
    jmp_sel     = $urandom_range(99) < jmp_pct;
    jmp_tgt     = (jmp_fix >= 0) ? 5'(jmp_fix) : 5'($urandom);
    newly = !m_valid;
    model_step(mem_ack, instr_ready, jmp_sel, int'(jmp_tgt));
    newly = newly && m_valid;
    @(posedge clk); #1;
    cyc++;
    if (req_pre) begin
      if (mem_ack) begin
        rsp_wait = 0; rsp_lat = pick_lat();
      end else begin
        rsp_wait++;
      end
    end
    if (mem_req) req_cnt++;
    if (newly) begin
      op_log.push_back(int'(opcode));
      pc_log.push_back(int'(pc));
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ack = 1'b0; instr_ready = 1'b0; jmp_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    addr_log.delete(); op_log.delete(); pc_log.delete();
    check_eq("rst_req", 32'(mem_req), 0);
    check_eq("rst_addr", 32'(mem_addr), 0);
    check_eq("rst_valid", 32'(instr_valid), 0);
    check_eq("rst_opcode", 32'(opcode), 0);
    check_eq("rst_imm", 32'(imm), 0);
    check_eq("rst_pc", 32'(pc), 0);
    check_eq("rst_halted", 32'(halted), 0);
    check_eq("rst_fault", 32'(fault), 0);
    check_eq("rst_retired", 32'(retired), 0);
  endtask

  task automatic random_rom();
    for (int i = 0; i < 32; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(14));
      if (op == HALT) op = 4'hF;
      rom[i] = {op, 5'($urandom)};
    end
  endtask

  initial begin
    rom_on = 1; stray_en = 0; lat_fixed = 0; lat_max = 0;
    ready_pct = 100; jmp_pct = 0; jmp_fix = -1; ready_limit = 0;

    // Zero-wait ROM, two instructions consumed back to back, stray ACK while idle
    for (int i = 0; i < 32; i++) rom[i] = '0;
    rom[0] = 9'h023;
    rom[1] = 9'h045;
    stray_en = 1; ready_limit = 2;
    do_reset();
    run(8);
    stray_en = 0;
    check_eq("t1_addr0", 32'(addr_log[0]), 0);
    check_eq("t1_addr1", 32'(addr_log[1]), 1);
    check_eq("t1_op0", 32'(op_log[0]), 1);
    check_eq("t1_op1", 32'(op_log[1]), 2);
    check_eq("t1_pc0", 32'(pc_log[0]), 0);
    check_eq("t1_pc1", 32'(pc_log[1]), 1);
    check_eq("t1_first_valid", 32'(first_valid_cyc), 2);
    check_eq("t1_retired", 32'(retired), 2);

    // ACK delayed three cycles: request held four cycles, valid the cycle after ACK
    random_rom();
    lat_fixed = 3; ready_limit = 0;
    do_reset();
    run(8);
    check_eq("t2_req_cycles", 32'(req_cnt), 4);
    check_eq("t2_first_valid", 32'(first_valid_cyc), 5);
    check_eq("t2_fault", 32'(fault), 0);

    // Jumps: to 20, to 31, wrap 31 -> 0, jump to the current PC
    lat_fixed = 0; jmp_pct = 100; jmp_fix = 20; ready_limit = 1;
    do_reset();
    run(6);
    check_eq("t3_jmp20", 32'(addr_log[$]), 20);
    jmp_fix = 31; ready_limit = 2;
    run(6);
    check_eq("t3_jmp31", 32'(addr_log[$]), 31);
    jmp_pct = 0; ready_limit = 3;
    run(6);
    check_eq("t3_wrap", 32'(addr_log[$]), 0);
    jmp_pct = 100; jmp_fix = 0; ready_limit = 4;
    run(6);
    check_eq("t3_self_jmp", 32'(addr_log[$]), 0);
    jmp_pct = 0; jmp_fix = -1;

    // Execute stage stalls for five cycles
    ready_limit = 0;
    do_reset();
    run(2);
    run(5);
    check_eq("t4_opcode", 32'(opcode), 32'(rom[0][8:5]));
    check_eq("t4_imm", 32'(imm), 32'(rom[0][4:0]));
    check_eq("t4_pc", 32'(pc), 0);
    check_eq("t4_req", 32'(mem_req), 0);
    check_eq("t4_retired", 32'(retired), 0);

    // HALT consumed, fetch stays stopped, reset restarts from address 0
    rom[1] = {HALT, 5'd7};
    ready_limit = 1000;
    do_reset();
    run(28);
    check_eq("t5_halted", 32'(halted), 1);
    check_eq("t5_retired", 32'(retired), 2);
    check_eq("t5_pc", 32'(pc), 1);
    do_reset();
    check_eq("t5_addr_after_rst", 32'(mem_addr), 0);

    // Memory never answers: fault after fifteen request cycles
    rom_on = 0;
    do_reset();
    run(20);
    check_eq("t6_fault", 32'(fault), 1);
    check_eq("t6_req_cycles", 32'(req_cnt), 15);

    // Reset during a fetch with ACK in the same cycle drops the data
    rom_on = 1; random_rom(); lat_fixed = 0;
    jmp_pct = 100; jmp_fix = 9; ready_limit = 1;
    do_reset();
    run(3);
    check_eq("t6_pre_rst_addr", 32'(mem_addr), 9);
    rst = 1'b1; mem_ack = 1'b1; mem_data = 9'h1A7; instr_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_rst_valid", 32'(instr_valid), 0);
    check_eq("t6_rst_pc", 32'(pc), 0);
    check_eq("t6_rst_opcode", 32'(opcode), 0);
    check_eq("t6_rst_req", 32'(mem_req), 0);
    rst = 1'b0; jmp_pct = 0; jmp_fix = -1;
    model_reset();
    run(6);

    // Random program, wait states, stalls and jumps; long enough to saturate RETIRED
    random_rom();
    lat_fixed = -1; lat_max = 4; ready_pct = 60; jmp_pct = 25; ready_limit = 300;
    do_reset();
    for (int i = 0; i < 6000 && consumed < 300; i++) cycle();
    check_eq("rand_consumed", 32'(consumed), 300);
    check_eq("rand_retired_sat", 32'(retired), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
